sn_stream: RTL and testbench
============================

// Module: sn_stream
// PURPOSE
//   Token-flow counterpart to the free-running sn Petri-net block: same 5-place net (t0:p0->p1,
//   t1:p3->p1, t2:p4->p2, with inhibitor arcs), but tokens enter via an input valid/ready
//   stream and are removed from sink places p1/p2 via an output valid/ready stream.
//   Sits between a token producer (host/test logic) and a token consumer; drives the board LEDs.
// PARAMETERS
//   W         32  place counter width (bits); all arithmetic saturates/guards at 2^W-1
//   P0_INIT   12  reset marking of p0
//   P3_INIT   5   reset marking of p3
//   P4_INIT   1   reset marking of p4
//   FIRE_CAP  63  max tokens moved by one firing (cap applied to every transition)
// PORTS
//   sys_clk    in   1   clock, all state on rising edge
//   sys_rst    in   1   asynchronous, active-high reset
//   in_valid   in   1   deposit request
//   in_ready   out  1   deposit accepted this cycle when in_valid&in_ready
//   in_place   in   2   target: 0=p0, 1=p3, 2=p4, 3=illegal (never ready)
//   in_count   in   6   tokens to deposit (0 legal, no-op transfer)
//   out_valid  out  1   a sink token is available
//   out_ready  in   1   consumer takes one token when out_valid&out_ready
//   out_src    out  1   0=token from p1, 1=token from p2
//   quiescent  out  1   no transition enabled on current marking
//   fire_cnt   out  16  number of firings since reset, wraps 0xFFFF->0
//   led        out  6   ~p1[5:0], registered
// BEHAVIOUR
//   Reset (async): p0=P0_INIT, p1=0, p2=0, p3=P3_INIT, p4=P4_INIT, fire_cnt=0, led=6'h3F.
//   Enable (from registered marking, cycle start): INH(x) = (x==0).
//     e0 = p0>0 & INH(p2); e1 = p3>0 & INH(p2); e2 = p4>0 & INH(p0) & INH(p2) & INH(p3).
//   Selection: fixed priority t0>t1>t2; at most one transition fires per cycle.
//     Fired amount n = min(FIRE_CAP, source place); consumes n, produces n (weight 1).
//   quiescent = ~(e0|e1|e2), combinational from registered marking.
//   Output: out_valid = (p1!=0)|(p2!=0); out_src = (p1==0). Drain removes exactly 1 token
//     from p1 if p1!=0 else from p2. p1 drains before p2 always.
//   Input: in_ready = (in_place!=3) & (target + in_count <= 2^W-1), evaluated on registered
//     marking; on transfer target += in_count.
//   Simultaneous events at one edge, all computed from start-of-cycle marking and summed:
//     place_next = place - fired_out + fired_in + deposit - drain. Firing never uses tokens
//     deposited the same cycle; drain never uses tokens produced the same cycle. No
//     underflow is possible. Sink overflow: a transition whose destination would exceed
//     2^W-1 is treated as not enabled (lower-priority transitions may then fire).
//   fire_cnt += 1 on each cycle a transition fires. led <= ~p1_next[5:0] every cycle.
//   Latency: deposit visible to enable logic 1 cycle after transfer; produced token visible
//     on out_valid 1 cycle after firing. Handshakes have no combinational in->out paths
//     except in_ready depending on in_place/in_count.
//   Reset mid-operation: marking, counters, LEDs return to reset values immediately;
//     in-flight handshakes are dropped (no partial deposit/drain).
// TESTING
//   1 Reset, in_valid=0, out_ready=0: cycle1 t0 fires 12 (p0=0,p1=12); cycle2 t1 fires 5
//     (p1=17); cycle3 t2 fires 1 (p2=1); then quiescent=1, fire_cnt=3, led=6'h2E.
//   2 From state of 1, out_ready=1: exactly 17 transfers with out_src=0 then 1 with
//     out_src=1; out_valid falls after 18th; led=6'h3F.
//   3 After 2, deposit in_place=0,in_count=3: next cycle t0 fires 3, p1=3, quiescent=1 after;
//     deposit in_place=2,count=1 then t2 fires 1, p2=1 (p0=p3=0).
//   4 W=8: p0=250, deposit count=6 -> in_ready=0; count=5 -> accepted, p0=255; in_place=3
//     -> in_ready=0 always.
//   5 Same-cycle deposit to p0, t0 firing and p1 drain: p0=p0-min(63,p0)+cnt, p1=p1+n-1.
//   6 Assert sys_rst between clock edges mid-drain: outputs return to reset values at once;
//     after release sequence 1 repeats exactly; fire_cnt wrap checked by forced 0xFFFF->0.

Source files
------------

// File: rtl/sn_stream.sv
// Token-flow Petri net: 5 places, 3 capped transitions with inhibitor arcs.
// Tokens are deposited through a valid/ready input and drained from p1/p2 through a valid/ready output.
module sn_stream #(
  parameter int W        = 32,
  parameter int P0_INIT  = 12,
  parameter int P3_INIT  = 5,
  parameter int P4_INIT  = 1,
  parameter int FIRE_CAP = 63
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_place,
  input  logic [5:0]  in_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_src,
  output logic        quiescent,
  output logic [15:0] fire_cnt,
  output logic [5:0]  led
);

  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] MAX_V  = {W{1'b1}};
  localparam logic [W-1:0] CAP_V  = W'(FIRE_CAP);

  function automatic logic [W-1:0] min_cap(input logic [W-1:0] x);
    return (x < CAP_V) ? x : CAP_V;
  endfunction

  logic [W-1:0] p0_q, p1_q, p2_q, p3_q, p4_q;
  logic [W-1:0] p0_d, p1_d, p2_d, p3_d, p4_d;
  logic [15:0]  fire_q, fire_d;
  logic [5:0]   led_q, led_d;

  logic [W-1:0] n0_s, n1_s, n2_s, tgt_s, cnt_s;
  logic         e0_s, e1_s, e2_s, f0_s, f1_s, f2_s;
  logic         in_ready_s, dep_s, drain_s, drain1_s, drain2_s;

  // Enables, priority selection and handshakes, all from the registered marking
  always_comb begin
    n0_s = min_cap(p0_q);
    n1_s = min_cap(p3_q);
    n2_s = min_cap(p4_q);
    // A firing that would overflow its sink is treated as not enabled
    e0_s = (p0_q != ZERO_V) && (p2_q == ZERO_V) && (n0_s <= MAX_V - p1_q);
    e1_s = (p3_q != ZERO_V) && (p2_q == ZERO_V) && (n1_s <= MAX_V - p1_q);
    e2_s = (p4_q != ZERO_V) && (p0_q == ZERO_V) && (p2_q == ZERO_V) &&
           (p3_q == ZERO_V) && (n2_s <= MAX_V - p2_q);
    f0_s = e0_s;
    f1_s = e1_s && !e0_s;
    f2_s = e2_s && !e0_s && !e1_s;

    case (in_place)
      2'd0:    tgt_s = p0_q;
      2'd1:    tgt_s = p3_q;
      2'd2:    tgt_s = p4_q;
      default: tgt_s = MAX_V;
    endcase
    cnt_s      = {{(W-6){1'b0}}, in_count};
    in_ready_s = (in_place != 2'd3) && (cnt_s <= MAX_V - tgt_s);
    dep_s      = in_valid && in_ready_s;

    drain_s  = ((p1_q != ZERO_V) || (p2_q != ZERO_V)) && out_ready;
    drain1_s = drain_s && (p1_q != ZERO_V);
    drain2_s = drain_s && (p1_q == ZERO_V);
  end

  // Next marking: firing, deposit and drain all sum against the start-of-cycle marking
  always_comb begin
    p0_d = p0_q;
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    p4_d = p4_q;
    if (f0_s) begin
      p0_d = p0_d - n0_s;
      p1_d = p1_d + n0_s;
    end else if (f1_s) begin
      p3_d = p3_d - n1_s;
      p1_d = p1_d + n1_s;
    end else if (f2_s) begin
      p4_d = p4_d - n2_s;
      p2_d = p2_d + n2_s;
    end else begin
      p0_d = p0_d;
    end
    if (dep_s) begin
      case (in_place)
        2'd0:    p0_d = p0_d + cnt_s;
        2'd1:    p3_d = p3_d + cnt_s;
        2'd2:    p4_d = p4_d + cnt_s;
        default: p0_d = p0_d;
      endcase
    end else begin
      p0_d = p0_d;
    end
    if (drain1_s) begin
      p1_d = p1_d - {{(W-1){1'b0}}, 1'b1};
    end else if (drain2_s) begin
      p2_d = p2_d - {{(W-1){1'b0}}, 1'b1};
    end else begin
      p1_d = p1_d;
    end
    if (f0_s || f1_s || f2_s) begin
      fire_d = fire_q + 16'd1;
    end else begin
      fire_d = fire_q;
    end
    led_d = ~p1_d[5:0];
  end

  // Marking, firing counter and LED registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p0_q   <= W'(P0_INIT);
      p1_q   <= ZERO_V;
      p2_q   <= ZERO_V;
      p3_q   <= W'(P3_INIT);
      p4_q   <= W'(P4_INIT);
      fire_q <= 16'd0;
      led_q  <= 6'h3F;
    end else begin
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      p3_q   <= p3_d;
      p4_q   <= p4_d;
      fire_q <= fire_d;
      led_q  <= led_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (p1_q != ZERO_V) || (p2_q != ZERO_V);
  assign out_src   = (p1_q == ZERO_V);
  assign quiescent = !(e0_s || e1_s || e2_s);
  assign fire_cnt  = fire_q;
  assign led       = led_q;

endmodule

// File: tb/tb_sn_stream.sv
// Bench for sn_stream: W=32 instance with a drain-order scoreboard, plus a W=8 instance for boundaries.
module tb_sn_stream;
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic in_valid, out_ready, in_ready, out_valid, out_src, quiescent;
  logic [1:0] in_place;
  logic [5:0] in_count, led;
  logic [15:0] fire_cnt;
  logic in_valid_b, out_ready_b, in_ready_b, out_valid_b, out_src_b, quiescent_b;
  logic [1:0] in_place_b;
  logic [5:0] in_count_b, led_b;
  logic [15:0] fire_cnt_b;

  int total = 0;
  int bad = 0;
  logic sb_q[$];
  logic exp_src;

  always #5 sys_clk = ~sys_clk;

  sn_stream dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_place(in_place), .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .quiescent(quiescent), .fire_cnt(fire_cnt), .led(led)
  );

  sn_stream #(.W(8)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_place(in_place_b), .in_count(in_count_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_src(out_src_b), .quiescent(quiescent_b), .fire_cnt(fire_cnt_b), .led(led_b)
  );

  // One clock; a drain handshake on the main DUT pops the scoreboard before the edge.
  task automatic tick();
    if (out_valid && out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL drain_unexpected got src=%0b required no transfer", out_src);
      end else begin
        exp_src = sb_q.pop_front();
        if (out_src !== exp_src) begin
          bad++;
          $display("FAIL drain_src got=%0b required=%0b", out_src, exp_src);
        end
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    in_valid = 1'b0; in_place = 2'd0; in_count = 6'd0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_place_b = 2'd0; in_count_b = 6'd0; out_ready_b = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    total++;
    if (led !== 6'h3F || fire_cnt !== 16'd0 || out_valid !== 1'b0 || quiescent !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got led=%h fire=%h ov=%b q=%b ir=%b required 3f 0000 0 0 1",
               led, fire_cnt, out_valid, quiescent, in_ready);
    end
    in_place = 2'd3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_illegal_place got=%b required=0", in_ready);
    end
    in_place = 2'd0;
    sys_rst = 1'b0;
  endtask

  task automatic test_seq();
    logic [5:0]  el [3];
    logic [15:0] ef [3];
    logic        eq [3];
    el = '{6'h33, 6'h2E, 6'h2E};
    ef = '{16'd1, 16'd2, 16'd3};
    eq = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (led !== el[i] || fire_cnt !== ef[i] || quiescent !== eq[i] || out_valid !== 1'b1 || out_src !== 1'b0) begin
        bad++;
        $display("FAIL seq_cycle%0d got led=%h fire=%0d q=%b ov=%b src=%b required led=%h fire=%0d q=%b ov=1 src=0",
                 i + 1, led, fire_cnt, quiescent, out_valid, out_src, el[i], ef[i], eq[i]);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    out_ready = 1'b1;
    repeat (18) tick();
    out_ready = 1'b0;
    total++;
    if (sb_q.size() != 0 || out_valid !== 1'b0 || led !== 6'h3F || fire_cnt !== 16'd3 || quiescent !== 1'b1) begin
      bad++;
      $display("FAIL drain_end got left=%0d ov=%b led=%h fire=%0d q=%b required 0 0 3f 3 1",
               sb_q.size(), out_valid, led, fire_cnt, quiescent);
    end
  endtask

  task automatic test_deposit();
    in_valid = 1'b1; in_place = 2'd0; in_count = 6'd3;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL dep_ready got=%b required=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (quiescent !== 1'b0 || fire_cnt !== 16'd3) begin
      bad++; $display("FAIL dep_visible got q=%b fire=%0d required q=0 fire=3", quiescent, fire_cnt);
    end
    tick();
    total++;
    if (led !== 6'h3C || fire_cnt !== 16'd4 || quiescent !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL dep_t0 got led=%h fire=%0d q=%b ov=%b required 3c 4 1 1", led, fire_cnt, quiescent, out_valid);
    end
    in_valid = 1'b1; in_place = 2'd2; in_count = 6'd1;
    tick();
    in_valid = 1'b0;
    total++;
    if (quiescent !== 1'b0) begin bad++; $display("FAIL dep_p4 got q=%b required 0", quiescent); end
    tick();
    total++;
    if (fire_cnt !== 16'd5 || quiescent !== 1'b1 || out_src !== 1'b0) begin
      bad++; $display("FAIL dep_t2 got fire=%0d q=%b src=%b required 5 1 0", fire_cnt, quiescent, out_src);
    end
  endtask

  task automatic test_same_cycle();
    sb_q.push_back(1'b0); sb_q.push_back(1'b0); sb_q.push_back(1'b0); sb_q.push_back(1'b1);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      bad++; $display("FAIL same_predrain got ov=%b left=%0d required 0 0", out_valid, sb_q.size());
    end
    in_valid = 1'b1; in_place = 2'd0; in_count = 6'd10;
    tick();
    in_count = 6'd20;
    tick();
    total++;
    if (led !== 6'h35 || fire_cnt !== 16'd6) begin
      bad++; $display("FAIL same_fire10 got led=%h fire=%0d required 35 6", led, fire_cnt);
    end
    in_count = 6'd5; out_ready = 1'b1; sb_q.push_back(1'b0);
    tick();
    total++;
    if (led !== 6'h22 || fire_cnt !== 16'd7) begin
      bad++; $display("FAIL same_all3 got led=%h fire=%0d required 22 7", led, fire_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    total++;
    if (led !== 6'h1D || fire_cnt !== 16'd8 || quiescent !== 1'b1) begin
      bad++; $display("FAIL same_fire5 got led=%h fire=%0d q=%b required 1d 8 1", led, fire_cnt, quiescent);
    end
  endtask

  task automatic test_w8();
    logic [5:0] dep [4];
    logic [5:0] el [5];
    dep = '{6'd63, 6'd63, 6'd63, 6'd61};
    el = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h00};
    in_valid_b = 1'b1; in_place_b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_count_b = dep[i];
      #1;
      total++;
      if (in_ready_b !== 1'b1) begin bad++; $display("FAIL w8_fill%0d got=%b required=1", i, in_ready_b); end
      tick();
    end
    in_count_b = 6'd6;
    #1;
    total++;
    if (in_ready_b !== 1'b0) begin bad++; $display("FAIL w8_over6 got=%b required=0", in_ready_b); end
    tick();
    in_count_b = 6'd5;
    #1;
    total++;
    if (in_ready_b !== 1'b1) begin bad++; $display("FAIL w8_fit5 got=%b required=1", in_ready_b); end
    tick();
    in_count_b = 6'd0;
    #1;
    total++;
    if (in_ready_b !== 1'b1) begin bad++; $display("FAIL w8_full0 got=%b required=1", in_ready_b); end
    in_count_b = 6'd1;
    #1;
    total++;
    if (in_ready_b !== 1'b0) begin bad++; $display("FAIL w8_full1 got=%b required=0", in_ready_b); end
    in_place_b = 2'd3; in_count_b = 6'd0;
    #1;
    total++;
    if (in_ready_b !== 1'b0) begin bad++; $display("FAIL w8_place3 got=%b required=0", in_ready_b); end
    in_valid_b = 1'b0; in_place_b = 2'd0;
    out_ready_b = 1'b1;
    repeat (17) tick();
    total++;
    if (out_valid_b !== 1'b1 || out_src_b !== 1'b1) begin
      bad++; $display("FAIL w8_p2last got ov=%b src=%b required 1 1", out_valid_b, out_src_b);
    end
    tick();
    out_ready_b = 1'b0;
    total++;
    if (out_valid_b !== 1'b0 || quiescent_b !== 1'b0 || fire_cnt_b !== 16'd3) begin
      bad++; $display("FAIL w8_drained got ov=%b q=%b fire=%0d required 0 0 3", out_valid_b, quiescent_b, fire_cnt_b);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (led_b !== el[i] || fire_cnt_b !== 16'(4 + i)) begin
        bad++; $display("FAIL w8_cap%0d got led=%h fire=%0d required led=%h fire=%0d", i, led_b, fire_cnt_b, el[i], 4 + i);
      end
    end
    in_valid_b = 1'b1; in_count_b = 6'd1;
    tick();
    in_valid_b = 1'b0;
    tick();
    total++;
    if (quiescent_b !== 1'b1 || fire_cnt_b !== 16'd8 || led_b !== 6'h00) begin
      bad++; $display("FAIL w8_sink_full got q=%b fire=%0d led=%h required 1 8 00", quiescent_b, fire_cnt_b, led_b);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) sb_q.push_back(1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    #2;
    sys_rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || led !== 6'h3F || fire_cnt !== 16'd0 || quiescent !== 1'b0) begin
      bad++; $display("FAIL rst_mid got ov=%b led=%h fire=%0d q=%b required 0 3f 0 0", out_valid, led, fire_cnt, quiescent);
    end
    sb_q.delete();
    out_ready = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    test_seq();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    out_ready = 1'b1;
    repeat (18) tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_place = 2'd0; in_count = 6'd1;
    for (int i = 0; i < 70000 && fire_cnt !== 16'hFFFF; i++) tick();
    total++;
    if (fire_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_reach got=%h required=ffff", fire_cnt); end
    tick();
    total++;
    if (fire_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h required=0000", fire_cnt); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_drain();
    test_deposit();
    test_same_cycle();
    test_w8();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
